// File: rtl/wb_pkg.sv
// Shared write-back definitions: bank geometry and the register-bank write port.
package wb_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NREG   = 8;
  localparam int unsigned ADDR_W = 3;

  // One write port into the register bank, as seen by each register.
  typedef struct packed {
    logic              regWrite;
    logic [NREG-1:0]   decOut;
    logic [DATA_W-1:0] wrData;
  } wrPort_t;

endpackage

// File: rtl/wb_dec.sv
// Register-index to one-hot select decoder with enable; all-zero when disabled.
module wb_dec #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned NREG   = 8
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] idx,
  output logic [NREG-1:0]   dec
);

  // Raise exactly the selected line, and only while enabled.
  always_comb begin
    dec = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      dec[i] = en && (idx == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: latches the MEM result, drives one write strobe per
// instruction into the register bank, reports forwarding hits to execute
// and counts committed writes (saturating).
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W   = wb_pkg::DATA_W,
  parameter int unsigned NREG     = wb_pkg::NREG,
  parameter int unsigned ADDR_W   = wb_pkg::ADDR_W,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_regWrite,
  input  logic              in_memToReg,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_aluResult,
  input  logic [DATA_W-1:0] in_memData,
  input  logic [ADDR_W-1:0] rs_a,
  input  logic [ADDR_W-1:0] rs_b,
  output logic              regWrite,
  output logic [NREG-1:0]   decOut,
  output logic [DATA_W-1:0] wrData,
  output logic              fwdHitA,
  output logic              fwdHitB,
  output logic [CNT_W-1:0]  wbCount
);

  logic              v;
  logic              wen;
  logic              done;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] data;
  logic [CNT_W-1:0]  cnt;
  logic              rdIsZero;
  logic              pend;

  // Stage register: reset > flush > stall > load. While stalled, done
  // remembers that the strobe already went out so it is not repeated.
  always_ff @(posedge clk) begin
    if (reset) begin
      v    <= 1'b0;
      wen  <= 1'b0;
      done <= 1'b0;
      rd   <= '0;
      data <= '0;
    end else if (flush) begin
      v    <= 1'b0;
      done <= 1'b0;
    end else if (stall) begin
      done <= done | regWrite;
    end else begin
      v    <= in_valid;
      wen  <= in_regWrite;
      done <= 1'b0;
      rd   <= in_rd;
      data <= in_memToReg ? in_memData : in_aluResult;
    end
  end

  // Pending write: still the youngest copy of rd until the bank holds it,
  // so forwarding keeps using it even after the strobe has been issued.
  always_comb begin
    rdIsZero = ZERO_REG && (rd == '0);
    pend     = v && wen && !rdIsZero;
    regWrite = pend && !done;
    wrData   = data;
    fwdHitA  = pend && (rs_a == rd);
    fwdHitB  = pend && (rs_b == rd);
  end

  wb_dec #(
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) uDec (
    .en  (regWrite),
    .idx (rd),
    .dec (decOut)
  );

  // Retired-write counter: one count per strobe, holds at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (regWrite && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign wbCount = cnt;

endmodule
